// File: rtl/median_pkg.sv
// Shared definitions for the SAR median estimator: FSM encoding, window-width
// derivation and the saturating magnitude used by every lane.
package median_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_UPDATE,
        ST_OUTPUT
    } state_e;

    function automatic int win_log(input int max_win);
        return $clog2(max_win);
    endfunction

    // |x| in w-1 bits; the most negative code has no positive twin, so it clips.
    function automatic int sat_mag(input int x, input int w);
        int lim;
        lim = (1 << (w - 1)) - 1;
        if (x >= 0)
            return x;
        else if (-x > lim)
            return lim;
        else
            return -x;
    endfunction

endpackage

// File: rtl/median_sar_lane.sv
// One channel of the estimator: magnitude, trial compare, hit counter,
// estimate register and per-window bit decision.
module median_sar_lane
    import median_pkg::*;
#(
    parameter int ADC_WIDTH = 14,
    parameter int CW        = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 acc_i,
    input  logic                 upd_i,
    input  logic                 pub_i,
    input  logic [ADC_WIDTH-2:0] bit_i,
    input  logic [CW-1:0]        n_i,
    input  logic [ADC_WIDTH-1:0] sample_i,
    output logic [ADC_WIDTH-2:0] median_o,
    output logic [CW-1:0]        count_o,
    output logic                 aob_o
);
    localparam int MW = ADC_WIDTH - 1;

    logic [MW-1:0] mag, est_q, est_d, med_q;
    logic [CW-1:0] cnt_q, cnt_d, count_q;
    logic          aob_q, dec;

    always_comb begin
        mag   = MW'(sat_mag(int'($signed(sample_i)), ADC_WIDTH));
        // Strict majority only, so a tie leaves the bit clear (lower median).
        dec   = {cnt_q, 1'b0} > {1'b0, n_i};
        est_d = est_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            est_d = '0;
            cnt_d = '0;
        end else if (upd_i) begin
            if (dec)
                est_d = est_q | bit_i;
            cnt_d = '0;
        end else if (acc_i && (mag >= (est_q | bit_i))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            est_q   <= '0;
            cnt_q   <= '0;
            count_q <= '0;
            aob_q   <= 1'b0;
            med_q   <= '0;
        end else begin
            est_q <= est_d;
            cnt_q <= cnt_d;
            if (upd_i && !clr_i) begin
                count_q <= cnt_q;
                aob_q   <= dec;
            end
            if (pub_i)
                med_q <= est_d;
        end
    end

    assign median_o = med_q;
    assign count_o  = count_q;
    assign aob_o    = aob_q;

endmodule

// File: rtl/median_sar_estimator.sv
// Multi-channel streaming median estimator: one shared FSM walks the bits
// MSB-first, one window of N samples per bit, across NUM_CH lanes.
module median_sar_estimator
    import median_pkg::*;
#(
    parameter  int ADC_WIDTH       = 14,
    parameter  int NUM_CH          = 8,
    parameter  int MAX_WINDOW_SIZE = 1024,
    localparam int WIN_LOG         = win_log(MAX_WINDOW_SIZE)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic                           start,
    input  logic                           continuous,
    input  logic [WIN_LOG-1:0]             window_size_cfg,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [ADC_WIDTH*NUM_CH-1:0]    s_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [(ADC_WIDTH-1)*NUM_CH-1:0] m_median,
    output logic [(WIN_LOG+1)*NUM_CH-1:0]  m_count,
    output logic [NUM_CH-1:0]              a_or_b,
    output logic                           busy
);
    localparam int MW = ADC_WIDTH - 1;
    localparam int CW = WIN_LOG + 1;

    state_e             state_q, state_d;
    logic [WIN_LOG-1:0] cfg_q, samp_q;
    logic [MW-1:0]      bit_q;
    logic               restart_q;
    logic               go, acc, win_end, upd, pub, clr;
    logic [CW-1:0]      n;

    assign go      = en && (state_q == ST_IDLE) && (start || restart_q);
    assign s_ready = en && (state_q == ST_COUNT);
    assign acc     = s_valid && s_ready;
    assign win_end = acc && (samp_q == cfg_q);
    assign upd     = en && (state_q == ST_UPDATE);
    assign pub     = upd && bit_q[0];
    assign clr     = go || !en;
    assign n       = CW'(cfg_q) + CW'(1);
    assign busy    = (state_q != ST_IDLE);
    assign m_valid = (state_q == ST_OUTPUT);

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (go) state_d = ST_COUNT;
                ST_COUNT:  if (win_end) state_d = ST_UPDATE;
                ST_UPDATE: state_d = bit_q[0] ? ST_OUTPUT : ST_COUNT;
                ST_OUTPUT: if (m_ready) state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cfg_q     <= '0;
            samp_q    <= '0;
            bit_q     <= '0;
            restart_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            // A one-cycle flag lets IDLE relaunch the search after a handshake.
            restart_q <= en && (state_q == ST_OUTPUT) && m_ready && continuous;
            if (go) begin
                cfg_q <= window_size_cfg;
                bit_q <= {1'b1, {(MW-1){1'b0}}};
            end else if (upd) begin
                bit_q <= bit_q >> 1;
            end
            if (clr || win_end)
                samp_q <= '0;
            else if (acc)
                samp_q <= samp_q + WIN_LOG'(1);
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        median_sar_lane #(
            .ADC_WIDTH (ADC_WIDTH),
            .CW        (CW)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr_i    (clr),
            .acc_i    (acc),
            .upd_i    (upd),
            .pub_i    (pub),
            .bit_i    (bit_q),
            .n_i      (n),
            .sample_i (s_data[c*ADC_WIDTH +: ADC_WIDTH]),
            .median_o (m_median[c*MW +: MW]),
            .count_o  (m_count[c*CW +: CW]),
            .aob_o    (a_or_b[c])
        );
    end

endmodule

// File: tb/tb_median_sar_estimator.sv
// Directed bench for median_sar_estimator with hand-computed expectations.
module tb_median_sar_estimator;
    localparam int AW = 14;
    localparam int NC = 8;
    localparam int MW = AW - 1;
    localparam int WL = 10;
    localparam int CW = WL + 1;

    logic             clk = 1'b0;
    logic             rst_n, en, start, continuous, s_valid, m_ready;
    logic [WL-1:0]    cfg;
    logic [AW*NC-1:0] s_data;
    logic             s_ready, m_valid, busy;
    logic [MW*NC-1:0] m_median;
    logic [CW*NC-1:0] m_count;
    logic [NC-1:0]    a_or_b;

    int passed = 0;
    int total  = 0;

    median_sar_estimator dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en              (en),
        .start           (start),
        .continuous      (continuous),
        .window_size_cfg (cfg),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_data          (s_data),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_median        (m_median),
        .m_count         (m_count),
        .a_or_b          (a_or_b),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input int v);
        s_data[c*AW +: AW] = AW'(v);
    endtask

    initial begin
        int cyc, idx, results;
        logic wacc;
        logic [MW*NC-1:0] saved, exp7;
        int seq[4];
        seq = '{10, 20, 30, 40};

        rst_n = 0; en = 0; start = 0; continuous = 0; s_valid = 0; m_ready = 0;
        cfg = 3; s_data = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_median", m_median, 0);
        chk("rst_count", m_count, 0);
        chk("rst_aob", a_or_b, 0);
        step(); rst_n = 1; step();

        // Constant inputs; a second start mid-search must not restart it.
        en = 1;
        set_ch(0, 100); set_ch(1, -100); set_ch(2, -8192);
        s_valid = 1; start = 1; step(); start = 0;
        cyc = 0;
        while (!m_valid && cyc < 200) begin
            cyc++;
            start = (cyc == 30);
            step();
        end
        start = 0;
        chk("latency", cyc, 65);
        chk("med_ch0", m_median[0*MW +: MW], 100);
        chk("med_ch1", m_median[1*MW +: MW], 100);
        chk("med_ch2_sat", m_median[2*MW +: MW], 8191);
        chk("med_ch3to7", m_median[MW*NC-1:3*MW], 0);
        chk("cnt_ch2", m_count[2*CW +: CW], 4);
        chk("cnt_ch0", m_count[0*CW +: CW], 0);
        chk("aob_final", a_or_b, 8'h04);

        // Backpressure in OUTPUT.
        saved = m_median;
        for (int i = 0; i < 5; i++) begin
            chk("hold_m_valid", m_valid, 1);
            chk("hold_median", m_median, saved);
            chk("hold_s_ready", s_ready, 0);
            step();
        end
        m_ready = 1; step(); m_ready = 0;
        chk("post_hs_busy", busy, 0);
        chk("post_hs_m_valid", m_valid, 0);

        // Repeating {10,20,30,40} on ch0 with periodic s_valid stalls.
        idx = 0; start = 1; step(); start = 0;
        cyc = 0;
        while (!m_valid && cyc < 400) begin
            s_valid = (cyc % 3 != 2);
            set_ch(0, seq[idx % 4]);
            wacc = s_valid && s_ready;
            step();
            if (wacc) idx++;
            cyc++;
        end
        chk("seq_done", m_valid, 1);
        chk("seq_accepted", idx, 52);
        chk("seq_med_ch0", m_median[0*MW +: MW], 20);
        chk("seq_cnt_ch0", m_count[0*CW +: CW], 2);
        m_ready = 1; step(); m_ready = 0;
        s_valid = 1;

        // Drop en in window 5.
        start = 1; step(); start = 0;
        repeat (22) step();
        chk("en_pre_busy", busy, 1);
        en = 0; step();
        chk("en_busy", busy, 0);
        chk("en_m_valid", m_valid, 0);
        chk("en_s_ready", s_ready, 0);
        chk("en_med_ch0", m_median[0*MW +: MW], 20);
        chk("en_med_ch2", m_median[2*MW +: MW], 8191);
        en = 1; step();

        // Continuous mode, N = 1.
        continuous = 1; cfg = 0; m_ready = 1;
        for (int c = 0; c < NC; c++) begin
            set_ch(c, 7);
            exp7[c*MW +: MW] = MW'(7);
        end
        start = 1; step(); start = 0;
        results = 0; cyc = 0;
        while (results < 3 && cyc < 500) begin
            if (m_valid) begin
                results++;
                chk($sformatf("cont_med%0d", results), m_median, exp7);
            end
            step();
            cyc++;
        end
        chk("cont_results", results, 3);
        repeat (5) step();
        chk("cont_busy", busy, 1);
        rst_n = 0; #1;
        chk("arst_busy", busy, 0);
        chk("arst_m_valid", m_valid, 0);
        chk("arst_s_ready", s_ready, 0);
        chk("arst_median", m_median, 0);
        chk("arst_count", m_count, 0);
        chk("arst_aob", a_or_b, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
